// File: rtl/seq_bit_serializer_pkg.sv
// rtl/seq_bit_serializer_pkg.sv - shared types and constants for the bit serializer
// Purpose: state encoding, default word width and counter-width helper.
package seq_bit_serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Bit counter must index 0..WIDTH-1 and never wrap past WIDTH-1.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/seq_hold_reg.sv
// rtl/seq_hold_reg.sv - one-entry valid/ready holding register
// Purpose: buffers one word so the shifter can stream back-to-back words.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   din, din_valid     incoming word and its valid
//   din_ready          high while the entry is empty (registered decode)
//   drain              consumer takes the held word this edge
//   dout, full         held word and occupancy flag
module seq_hold_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             drain,
    output logic [WIDTH-1:0] dout,
    output logic             full
);

    // Accept requires empty, drain requires full, so they never coincide.
    always_ff @(posedge clk) begin
        if (rst) begin
            full <= 1'b0;
            dout <= '0;
        end else if (din_valid && !full) begin
            full <= 1'b1;
            dout <= din;
        end else if (drain) begin
            full <= 1'b0;
        end
    end

    assign din_ready = !full;

endmodule

// File: rtl/seq_bit_serializer.sv
// rtl/seq_bit_serializer.sv - parallel-to-serial front end for sequence detectors
// Purpose: accepts WIDTH-bit words over valid/ready and emits one bit per clock.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   din, din_valid, din_ready  word input handshake
//   sout, sout_valid         registered serial bit and its qualifier
//   sout_last                registered flag on the final bit of each word
//   busy                     shifter active or holding register full
module seq_bit_serializer
    import seq_bit_serializer_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             sout_last,
    output logic             busy
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] hold_data;
    logic             hold_full;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_next;
    logic [CNT_W-1:0] bit_cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             sout_next;
    logic             valid_next;
    logic             last_next;
    logic             at_last;
    logic             load;

    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    seq_hold_reg #(
        .WIDTH(WIDTH)
    ) u_hold (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .din_valid(din_valid),
        .din_ready(din_ready),
        .drain    (load),
        .dout     (hold_data),
        .full     (hold_full)
    );

    // The bit currently on sout is the final one of its word.
    assign at_last = (state == SHIFT) && (bit_cnt == LAST_IDX);
    // Load from hold when idle, or right after the last bit for a gapless stream.
    assign load    = hold_full && ((state == IDLE) || at_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (hold_full) state_next = SHIFT;
            SHIFT:   if (at_last && !hold_full) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // shreg keeps the whole word with the bit on sout still in the output
    // position; zero fill makes it all-zero once the word has gone out.
    always_comb begin
        shreg_next = '0;
        cnt_next   = '0;
        sout_next  = 1'b0;
        valid_next = 1'b0;
        if (load) begin
            shreg_next = hold_data;
            sout_next  = first_bit(hold_data);
            valid_next = 1'b1;
        end else if ((state == SHIFT) && !at_last) begin
            shreg_next = shift_once(shreg);
            sout_next  = first_bit(shreg_next);
            cnt_next   = bit_cnt + CNT_W'(1);
            valid_next = 1'b1;
        end
        last_next = valid_next && (cnt_next == LAST_IDX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg      <= '0;
            bit_cnt    <= '0;
            sout       <= 1'b0;
            sout_valid <= 1'b0;
            sout_last  <= 1'b0;
        end else begin
            shreg      <= shreg_next;
            bit_cnt    <= cnt_next;
            sout       <= sout_next;
            sout_valid <= valid_next;
            sout_last  <= last_next;
        end
    end

    assign busy = (state == SHIFT) || hold_full;

endmodule

// File: tb/tb_seq_bit_serializer.sv
// tb/tb_seq_bit_serializer.sv - self-checking bench for seq_bit_serializer
module tb_seq_bit_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic       din_valid;

    logic m_ready, m_sout, m_valid, m_last, m_busy;
    logic l_ready, l_sout, l_valid, l_last, l_busy;

    always #5 clk = ~clk;

    seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .din_ready(m_ready), .sout(m_sout), .sout_valid(m_valid),
        .sout_last(m_last), .busy(m_busy)
    );

    seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .din_ready(l_ready), .sout(l_sout), .sout_valid(l_valid),
        .sout_last(l_last), .busy(l_busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: queue of accepted words; the head word emits one bit
    // per edge once it has been in the queue for at least one edge.
    logic [7:0] wq[$];
    int         sent = 0;
    logic       e_valid = 1'b0, e_msb = 1'b0, e_lsb = 1'b0, e_last = 1'b0;
    int         ones_run = 0;
    logic       det_seen = 1'b0;

    function automatic bit unstarted();
        return (wq.size() > 1) || (wq.size() == 1 && sent == 0);
    endfunction

    task automatic step(input logic r, input logic v, input logic [7:0] d, output bit acc);
        logic       rdy;
        logic [7:0] w;
        rst       = r;
        din_valid = v;
        din       = d;
        rdy       = !unstarted();
        acc       = 1'b0;
        @(posedge clk);
        e_valid = 1'b0; e_msb = 1'b0; e_lsb = 1'b0; e_last = 1'b0;
        if (r) begin
            wq.delete();
            sent = 0;
        end else begin
            if (wq.size() > 0) begin
                w       = wq[0];
                e_valid = 1'b1;
                e_msb   = w[7 - sent];
                e_lsb   = w[sent];
                e_last  = (sent == 7);
                sent++;
                if (sent == 8) begin
                    void'(wq.pop_front());
                    sent = 0;
                end
            end
            if (v && rdy) begin
                wq.push_back(d);
                acc = 1'b1;
            end
        end
        #1;
        chk("msb_valid", m_valid, e_valid);
        chk("msb_sout",  m_sout,  e_msb);
        chk("msb_last",  m_last,  e_last);
        chk("msb_busy",  m_busy,  e_valid || unstarted());
        chk("msb_ready", m_ready, !unstarted());
        chk("lsb_valid", l_valid, e_valid);
        chk("lsb_sout",  l_sout,  e_lsb);
        chk("lsb_last",  l_last,  e_last);
        chk("lsb_busy",  l_busy,  e_valid || unstarted());
        chk("lsb_ready", l_ready, !unstarted());
        // Three-ones detector fed from the LSB-first stream.
        if (l_valid && l_sout) ones_run++;
        else ones_run = 0;
        if (ones_run >= 3) det_seen = 1'b1;
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'($urandom), acc);
    endtask

    task automatic send(input logic [7:0] d);
        bit acc = 1'b0;
        for (int k = 0; k < 40 && !acc; k++) step(1'b0, 1'b1, d, acc);
        if (!acc) chk("send_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        bit acc;
        rst = 1'b1; din_valid = 1'b1; din = 8'h5A;
        // Reset held with din_valid high: nothing may be taken.
        step(1'b1, 1'b1, 8'h5A, acc);
        step(1'b1, 1'b1, 8'hC3, acc);
        idle(3);

        // Single word, then drain.
        send(8'hE0);
        idle(12);

        // Back-to-back with din_valid held high.
        send(8'hFF);
        send(8'h0F);
        idle(20);

        // Backpressure: three words presented while the shifter is busy.
        send(8'h3C);
        send(8'h81);
        send(8'h96);
        idle(30);

        // LSB-first 8'h07 drives three consecutive ones into the detector.
        det_seen = 1'b0;
        send(8'h07);
        idle(12);
        chk("detector_3ones", det_seen, 1'b1);

        // Reset while bit index 3 of 8'hAA is on sout and 8'h55 is held.
        send(8'hAA);
        send(8'h55);
        for (int k = 0; k < 20 && sent != 4; k++) step(1'b0, 1'b0, 8'h00, acc);
        chk("reset_point", sent, 4);
        step(1'b1, 1'b0, 8'h00, acc);
        idle(20);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++)
            step(($urandom_range(0, 149) == 0), 1'($urandom_range(0, 1)), 8'($urandom), acc);
        idle(30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seq_bit_serializer.md
Name: seq_bit_serializer

Overview:
- Parallel-to-serial front end for the team's serial sequence detectors.
- Accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock on `sout`.
- `sout` drives the detectors' serial `in` input directly.
- A one-word holding register lets consecutive words stream with no idle bit between them.

Parameters:
- WIDTH, 8, word width in bits; legal range 2..32.
- MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- din  input  WIDTH  parallel word.
- din_valid  input  1  `din` holds a valid word.
- din_ready  output  1  serializer can take a word this cycle.
- sout  output  1  serial bit; drives the detector `in` port.
- sout_valid  output  1  `sout` carries a real data bit.
- sout_last  output  1  high with the final bit of each word.
- busy  output  1  shifter active or holding register full.

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: sout=0, sout_valid=0, sout_last=0, busy=0, din_ready=1. Holding register empties; shift register, bit counter and state clear to 0/IDLE.
- Reset mid-word: the partial word and any held word are discarded. On the next edge sout=0 and sout_valid=0; no remaining bits are emitted.
- Handshake:
  - A transfer occurs at a rising edge when din_valid && din_ready.
  - din_ready = !hold_full, decoded from a register only; it has no combinational path from din_valid.
  - A word accepted at edge N is placed in the holding register.
  - din_valid may drop or change freely while din_ready=0; the block ignores it.
- State machine, two states:
  - IDLE: on an edge with hold_full=1, load the shift register from hold, clear hold_full, drive the first bit on sout with sout_valid=1, set bit_cnt=0, go to SHIFT. Otherwise sout=0 and sout_valid=0.
  - SHIFT: each edge advances one bit and increments bit_cnt.
  - On the edge after the last bit (bit_cnt==WIDTH-1): if hold_full, load the next word and send its first bit on that same edge, staying in SHIFT (gapless). Otherwise go to IDLE, with sout=0 and sout_valid=0.
- Latency: word accepted at edge N; its first bit is registered on sout at edge N+1 when the shifter is idle.
- sout, sout_valid and sout_last are all registered outputs.
- Idle fill is 0, so downstream detectors see zeros and fall back to their start state between bursts.
- sout_last=1 exactly when the bit on sout is bit index WIDTH-1 of the sending order.
- Hold register:
  - Can be refilled on the edge after it drains.
  - Drain and accept never happen on the same edge, because din_ready was 0 while full.
  - WIDTH>=2 guarantees that refill completes before the current word ends, so the stream stays gapless.
- busy = (state==SHIFT) || hold_full.
- bit_cnt width is $clog2(WIDTH). It must not wrap past WIDTH-1.
- Shifting: left for MSB_FIRST=1, right otherwise; vacated bits are zero-filled.

Decomposition:
- Shared package/header holds:
  - state encodings (IDLE, SHIFT);
  - the default WIDTH;
  - a clog2-based localparam for the counter width.
- A sub-module is not needed: holding register, shifter and FSM sit in one module.
- Optional sub-module, `seq_hold_reg`, for the one-entry valid/ready buffer if it is later reused.

Test Plan:
- Reset → sout=0, sout_valid=0, sout_last=0, busy=0, din_ready=1. Hold rst=1 for 2 cycles with din_valid=1: no transfer occurs.
- Single word 8'hE0, MSB_FIRST=1, accepted at edge N → sout over edges N+1..N+8 = 1,1,1,0,0,0,0,0; sout_valid high for exactly 8 cycles; sout_last only at N+8; then sout=0, sout_valid=0.
- Back-to-back 8'hFF then 8'h0F, din_valid held high → 16 contiguous valid bits FF then 0F with no gap. din_ready drops after the second accept and rises the edge after the second word loads.
- Backpressure: present 3 words while the shifter is busy → din_ready=0 while hold is full; all 3 words emerge in order with none lost or duplicated.
- MSB_FIRST=0, word 8'h07 → sout = 1,1,1,0,0,0,0,0. Feed into the 3-ones detector: its output asserts after the third 1.
- Reset asserted at bit index 3 of 8'hAA with a second word held → sout=0 and sout_valid=0 from the next edge, busy=0, din_ready=1. Neither word's remaining bits ever appear.
